// File: rtl/adaptive_threshold.sv
`default_nettype none
// ============================================================================
//  Module      : adaptive_threshold
//  Description : Binarises a filtered 7-bit pixel stream against a threshold
//                that follows the previous frame's mean brightness. The
//                mean comes from a restoring divider that runs during
//                blanking after end of frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module adaptive_threshold #(
    parameter int                 H_ACTIVE    = 320,
    parameter int                 V_ACTIVE    = 180,
    parameter int                 INIT_THRESH = 64,
    parameter logic signed [7:0]  OFFSET      = 8'sd0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [6:0]  pixel_data_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        data_valid_out,
    output logic        mask_out,
    output logic [6:0]  pixel_data_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [6:0]  threshold_out,
    output logic        frame_done_out
);

    localparam logic [10:0] C_H_ACTIVE    = 11'(H_ACTIVE);
    localparam logic [9:0]  C_V_ACTIVE    = 10'(V_ACTIVE);
    localparam logic [10:0] C_H_LAST      = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  C_V_LAST      = 10'(V_ACTIVE - 1);
    localparam logic [6:0]  C_INIT_THRESH = 7'(INIT_THRESH);
    localparam logic [4:0]  C_LAST_BIT    = 5'd22;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t              r_state;
    logic [22:0]         r_sum;
    logic [16:0]         r_cnt;
    logic [22:0]         r_quo;     // dividend shifting out, quotient shifting in
    logic [16:0]         r_div;
    logic [17:0]         r_rem;
    logic [4:0]          r_bit;
    logic [6:0]          r_thresh;
    logic                r_commit;

    logic                w_count;
    logic                w_eof;
    logic [22:0]         w_sum_next;
    logic [16:0]         w_cnt_next;
    logic [17:0]         w_rem_shift;
    logic [18:0]         w_trial;
    logic                w_no_borrow;
    logic signed [24:0]  w_t;
    logic [6:0]          w_clamped;

    // Which pixels contribute to the frame statistics, and where the frame ends
    assign w_count    = data_valid_in && (hcount_in < C_H_ACTIVE) && (vcount_in < C_V_ACTIVE);
    assign w_eof      = w_count && (hcount_in == C_H_LAST) && (vcount_in == C_V_LAST);
    assign w_sum_next = r_sum + {16'd0, pixel_data_in};
    assign w_cnt_next = r_cnt + 17'd1;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    // A set remainder MSB means the shifted value exceeds any 17-bit divisor.
    assign w_rem_shift = {r_rem[16:0], r_quo[22]};
    assign w_trial     = {1'b0, w_rem_shift} - {2'b00, r_div};
    assign w_no_borrow = r_rem[17] | ~w_trial[18];

    // Biased mean, clamped into the 7-bit pixel range
    assign w_t = $signed({2'b00, r_quo}) + $signed({{17{OFFSET[7]}}, OFFSET});
    always_comb begin
        w_clamped = w_t[6:0];
        if (w_t[24]) begin
            w_clamped = 7'd0;
        end else if (w_t > 25'sd127) begin
            w_clamped = 7'd127;
        end
    end

    assign threshold_out = r_thresh;

    // Stream path: register pixel, coordinates and mask with one-cycle latency
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_valid_out <= 1'b0;
            mask_out       <= 1'b0;
            pixel_data_out <= 7'd0;
            hcount_out     <= 11'd0;
            vcount_out     <= 10'd0;
        end else begin
            data_valid_out <= data_valid_in;
            mask_out       <= data_valid_in & (pixel_data_in >= r_thresh);
            pixel_data_out <= pixel_data_in;
            hcount_out     <= hcount_in;
            vcount_out     <= vcount_in;
        end
    end

    // Frame statistics: accumulate active pixels, restart at every end of frame
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sum <= 23'd0;
            r_cnt <= 17'd0;
        end else if (w_eof) begin
            r_sum <= 23'd0;
            r_cnt <= 17'd0;
        end else if (w_count) begin
            r_sum <= w_sum_next;
            r_cnt <= w_cnt_next;
        end
    end

    // Control FSM: latch frame totals, divide bit-serially, commit threshold
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_quo          <= 23'd0;
            r_div          <= 17'd0;
            r_rem          <= 18'd0;
            r_bit          <= 5'd0;
            r_thresh       <= C_INIT_THRESH;
            r_commit       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            r_commit       <= (r_state == S_UPDATE);
            frame_done_out <= r_commit;
            case (r_state)
                S_IDLE: begin
                    // An end of frame seen while busy is simply not latched
                    if (w_eof) begin
                        r_quo   <= w_sum_next;
                        r_div   <= w_cnt_next;
                        r_rem   <= 18'd0;
                        r_bit   <= 5'd0;
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_no_borrow ? w_trial[17:0] : w_rem_shift;
                    r_quo <= {r_quo[21:0], w_no_borrow};
                    if (r_bit == C_LAST_BIT) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_bit <= r_bit + 5'd1;
                    end
                end
                S_UPDATE: begin
                    r_thresh <= w_clamped;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adaptive_threshold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adaptive_threshold
//  Description : Directed bench for adaptive_threshold. One full-size
//                instance plus three small-geometry instances (8x4 frames)
//                with different biases share a single input stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adaptive_threshold;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [6:0]  pix;
    logic [10:0] hc;
    logic [9:0]  vc;

    logic        dv_m, mk_m, fd_m;
    logic [6:0]  px_m, th_m;
    logic [10:0] hc_m;
    logic [9:0]  vc_m;

    logic        dv_s0, mk_s0, fd_s0;
    logic [6:0]  px_s0, th_s0;
    logic [10:0] hc_s0;
    logic [9:0]  vc_s0;

    logic        dv_sn, mk_sn, fd_sn;
    logic [6:0]  px_sn, th_sn;
    logic [10:0] hc_sn;
    logic [9:0]  vc_sn;

    logic        dv_sp, mk_sp, fd_sp;
    logic [6:0]  px_sp, th_sp;
    logic [10:0] hc_sp;
    logic [9:0]  vc_sp;

    int n_checks = 0;
    int n_errors = 0;

    adaptive_threshold dut_m (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid), .pixel_data_in(pix),
        .hcount_in(hc), .vcount_in(vc), .data_valid_out(dv_m), .mask_out(mk_m),
        .pixel_data_out(px_m), .hcount_out(hc_m), .vcount_out(vc_m),
        .threshold_out(th_m), .frame_done_out(fd_m)
    );

    adaptive_threshold #(.H_ACTIVE(8), .V_ACTIVE(4), .INIT_THRESH(64), .OFFSET(8'sd0)) dut_s0 (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid), .pixel_data_in(pix),
        .hcount_in(hc), .vcount_in(vc), .data_valid_out(dv_s0), .mask_out(mk_s0),
        .pixel_data_out(px_s0), .hcount_out(hc_s0), .vcount_out(vc_s0),
        .threshold_out(th_s0), .frame_done_out(fd_s0)
    );

    adaptive_threshold #(.H_ACTIVE(8), .V_ACTIVE(4), .INIT_THRESH(64), .OFFSET(-8'sd80)) dut_sn (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid), .pixel_data_in(pix),
        .hcount_in(hc), .vcount_in(vc), .data_valid_out(dv_sn), .mask_out(mk_sn),
        .pixel_data_out(px_sn), .hcount_out(hc_sn), .vcount_out(vc_sn),
        .threshold_out(th_sn), .frame_done_out(fd_sn)
    );

    adaptive_threshold #(.H_ACTIVE(8), .V_ACTIVE(4), .INIT_THRESH(64), .OFFSET(8'sd100)) dut_sp (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid), .pixel_data_in(pix),
        .hcount_in(hc), .vcount_in(vc), .data_valid_out(dv_sp), .mask_out(mk_sp),
        .pixel_data_out(px_sp), .hcount_out(hc_sp), .vcount_out(vc_sp),
        .threshold_out(th_sp), .frame_done_out(fd_sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [6:0]  p;
        logic [10:0] h;
        logic [9:0]  vv;
        logic        ev;
        logic        em;
        logic [6:0]  ethr;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] p, input logic [10:0] h, input logic [9:0] vv);
        valid = v;
        pix   = p;
        hc    = h;
        vc    = vv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 7'd0, 11'd0, 10'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sends one frame; optional out-of-range pixels and an invalid cycle are
    // placed at the start of each line so the end-of-frame pixel comes last.
    task automatic send_frame(input int hmax, input int vmax, input logic [6:0] left,
                              input logic [6:0] right, input bit extras);
        for (int y = 0; y < vmax; y++) begin
            if (extras) begin
                for (int i = 0; i < 4; i++) begin
                    drive(1'b1, 7'd127, 11'(hmax + i), 10'(y));
                    tick();
                end
                drive(1'b0, 7'd127, 11'd0, 10'(y));
                tick();
            end
            for (int x = 0; x < hmax; x++) begin
                drive(1'b1, (x < hmax / 2) ? left : right, 11'(x), 10'(y));
                tick();
            end
        end
        drive(1'b0, 7'd0, 11'd0, 10'd0);
    endtask

    // Watches dut_s0 after its end-of-frame edge: threshold flips on the 24th
    // following edge, frame_done on the 25th, and only once.
    task automatic run_commit(input int old_thr, input int new_thr);
        int pulses;
        int at_k;
        pulses = 0;
        at_k   = -1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 23) chk("s0_thr_before", th_s0, old_thr);
            if (k == 24) chk("s0_thr_after", th_s0, new_thr);
            if (fd_s0) begin
                pulses++;
                at_k = k;
            end
        end
        chk("s0_done_pulses", pulses, 1);
        chk("s0_done_cycle", at_k, 25);
    endtask

    initial begin
        int pulses;
        int at_k;

        rst = 1'b1;
        drive(1'b0, 7'd0, 11'd0, 10'd0);
        tick();
        tick();
        // Reset state
        chk("rst_valid", dv_m, 0);
        chk("rst_mask", mk_m, 0);
        chk("rst_pixel", px_m, 0);
        chk("rst_hcount", hc_m, 0);
        chk("rst_vcount", vc_m, 0);
        chk("rst_thr", th_m, 64);
        chk("rst_done", fd_m, 0);
        chk("rst_thr_s0", th_s0, 64);
        rst = 1'b0;

        // ---------------- Test 1: stream path, table-driven ----------------
        tbl[0] = '{v:1'b1, p:7'd70,  h:11'd5,   vv:10'd5,   ev:1'b1, em:1'b1, ethr:7'd64};
        tbl[1] = '{v:1'b1, p:7'd63,  h:11'd6,   vv:10'd5,   ev:1'b1, em:1'b0, ethr:7'd64};
        tbl[2] = '{v:1'b1, p:7'd64,  h:11'd7,   vv:10'd5,   ev:1'b1, em:1'b1, ethr:7'd64};
        tbl[3] = '{v:1'b0, p:7'd127, h:11'd8,   vv:10'd5,   ev:1'b0, em:1'b0, ethr:7'd64};
        tbl[4] = '{v:1'b1, p:7'd0,   h:11'd400, vv:10'd900, ev:1'b1, em:1'b0, ethr:7'd64};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].h, tbl[i].vv);
            tick();
            chk($sformatf("t1_valid[%0d]", i), dv_m, tbl[i].ev);
            chk($sformatf("t1_mask[%0d]", i), mk_m, tbl[i].em);
            chk($sformatf("t1_pixel[%0d]", i), px_m, tbl[i].p);
            chk($sformatf("t1_hcount[%0d]", i), hc_m, tbl[i].h);
            chk($sformatf("t1_vcount[%0d]", i), vc_m, tbl[i].vv);
            chk($sformatf("t1_thr[%0d]", i), th_m, tbl[i].ethr);
        end

        // ---------------- Test 2: full-size frame of 100s ----------------
        do_reset();
        send_frame(320, 180, 7'd100, 7'd100, 1'b0);
        pulses = 0;
        at_k   = -1;
        drive(1'b1, 7'd80, 11'd400, 10'd0);
        for (int k = 1; k <= 32; k++) begin
            if (k == 25) drive(1'b1, 7'd99, 11'd400, 10'd0);
            if (k == 26) drive(1'b1, 7'd100, 11'd400, 10'd0);
            if (k == 27) drive(1'b0, 7'd0, 11'd0, 10'd0);
            tick();
            if (k == 23) chk("t2_thr_before", th_m, 64);
            if (k == 24) begin
                chk("t2_thr_after", th_m, 100);
                chk("t2_mask_update_cycle", mk_m, 1);
            end
            if (k == 25) chk("t2_mask_99", mk_m, 0);
            if (k == 26) chk("t2_mask_100", mk_m, 1);
            if (fd_m) begin
                pulses++;
                at_k = k;
            end
        end
        chk("t2_done_pulses", pulses, 1);
        chk("t2_done_cycle", at_k, 25);

        // ---------------- Test 3: mean 70 with clamping biases ----------------
        do_reset();
        send_frame(8, 4, 7'd20, 7'd120, 1'b0);
        run_commit(64, 70);
        chk("t3_thr_neg_clamp", th_sn, 0);
        chk("t3_thr_pos_clamp", th_sp, 127);
        chk("t3_thr_main_partial", th_m, 64);

        // ---------------- Test 4: out-of-range and invalid pixels ----------------
        drive(1'b1, 7'd127, 11'd9, 10'd0);
        tick();
        chk("t4_oor_mask_hi", mk_s0, 1);
        chk("t4_oor_hcount", hc_s0, 9);
        chk("t4_oor_pixel", px_s0, 127);
        drive(1'b1, 7'd10, 11'd10, 10'd2);
        tick();
        chk("t4_oor_mask_lo", mk_s0, 0);
        send_frame(8, 4, 7'd10, 7'd10, 1'b1);
        run_commit(70, 10);
        chk("t4_thr_neg", th_sn, 0);
        chk("t4_thr_pos", th_sp, 110);

        // ---------------- Test 5: second EOF during DIVIDE ----------------
        send_frame(8, 4, 7'd40, 7'd40, 1'b0);
        pulses = 0;
        at_k   = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) drive(1'b1, 7'd90, 11'd7, 10'd3);
            else        drive(1'b0, 7'd0, 11'd0, 10'd0);
            tick();
            if (k == 23) chk("t5_thr_before", th_s0, 10);
            if (k == 24) chk("t5_thr_after", th_s0, 40);
            if (fd_s0) begin
                pulses++;
                at_k = k;
            end
        end
        chk("t5_done_pulses", pulses, 1);
        chk("t5_done_cycle", at_k, 25);
        send_frame(8, 4, 7'd50, 7'd50, 1'b0);
        run_commit(40, 50);

        // ---------------- Test 6: reset in the middle of DIVIDE ----------------
        send_frame(8, 4, 7'd30, 7'd30, 1'b0);
        drive(1'b1, 7'd100, 11'd2, 10'd1);
        for (int k = 1; k <= 10; k++) tick();
        chk("t6_pre_valid", dv_s0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", dv_s0, 0);
        chk("t6_async_mask", mk_s0, 0);
        chk("t6_async_pixel", px_s0, 0);
        chk("t6_async_hcount", hc_s0, 0);
        chk("t6_async_vcount", vc_s0, 0);
        chk("t6_async_thr", th_s0, 64);
        chk("t6_async_done", fd_s0, 0);
        drive(1'b0, 7'd0, 11'd0, 10'd0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (fd_s0) pulses++;
        end
        chk("t6_no_done", pulses, 0);
        chk("t6_thr_init", th_s0, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
